minesweeper_game_ctrl: RTL and testbench

Parametrised game-control engine for the minesweeper design: one-hot game FSM (INIT/PLAY/WIN/LOSE), cursor with optional wrap-around, remaining-safe-cell counter, signed flag counter and elapsed-seconds timer. Sits between the debounced button pulses and the board/board_cover arrays. It drives their cursor coordinates and open/flag requests, and it feeds the VGA and SSD display paths.

---
 rtl/minesweeper_game_ctrl_if.sv | 55 +++++
 rtl/minesweeper_game_ctrl.sv | 170 +++++++++++++++++
 tb/tb_minesweeper_game_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/minesweeper_game_ctrl_if.sv
// minesweeper_game_ctrl_if
//   Bundles the signals between the game-control engine and its surroundings:
//   debounced button pulses, board/cover-array status pulses, and the
//   cursor/request/counter outputs that feed the cover array and displays.
//   Modports:
//     slave  - the game-control engine (consumes pulses, drives outputs)
//     master - the environment (board, cover array, buttons, displays)
//   Parameters: X_BITS / Y_BITS cursor widths; CNT_W = X_BITS+Y_BITS+1.
interface minesweeper_game_ctrl_if #(
  parameter int X_BITS = 4,
  parameter int Y_BITS = 4
);
  localparam int CNT_W = X_BITS + Y_BITS + 1;

  logic             new_game;
  logic             init_done;
  logic [CNT_W-1:0] num_mines;
  logic [CNT_W-1:0] num_non_mines;
  logic             mv_l;
  logic             mv_r;
  logic             mv_u;
  logic             mv_d;
  logic             wrap_en;
  logic             act_open;
  logic             act_flag;
  logic             cell_opened;
  logic             cell_is_mine;
  logic             flag_changed;
  logic             flag_set;

  logic [3:0]        state;
  logic [X_BITS-1:0] x_pos;
  logic [Y_BITS-1:0] y_pos;
  logic              open_req;
  logic              flag_req;
  logic [CNT_W-1:0]  cells_to_open;
  logic [CNT_W:0]    flags_left;
  logic [9:0]        elapsed_sec;

  modport slave (
    input  new_game, init_done, num_mines, num_non_mines,
    input  mv_l, mv_r, mv_u, mv_d, wrap_en, act_open, act_flag,
    input  cell_opened, cell_is_mine, flag_changed, flag_set,
    output state, x_pos, y_pos, open_req, flag_req,
    output cells_to_open, flags_left, elapsed_sec
  );

  modport master (
    output new_game, init_done, num_mines, num_non_mines,
    output mv_l, mv_r, mv_u, mv_d, wrap_en, act_open, act_flag,
    output cell_opened, cell_is_mine, flag_changed, flag_set,
    input  state, x_pos, y_pos, open_req, flag_req,
    input  cells_to_open, flags_left, elapsed_sec
  );
endinterface

// File: rtl/minesweeper_game_ctrl.sv
// minesweeper_game_ctrl
//   Game-control engine: one-hot game FSM (INIT/PLAY/WIN/LOSE), cursor with
//   optional wrap-around, remaining-safe-cell counter, signed flag counter and
//   an optional elapsed-seconds timer.
//   Ports:
//     clk      - system clock, all state on rising edge
//     reset_n  - asynchronous active-low reset
//     bus      - minesweeper_game_ctrl_if.slave (pulses in, cursor/requests/
//                counters out; see the interface file)
//   Build option:
//     MINESWEEPER_TIMER_EN - when defined, the tick divider and elapsed_sec
//                            counter are built; otherwise elapsed_sec is 0.
module minesweeper_game_ctrl #(
  parameter int X_SIZE    = 16,
  parameter int Y_SIZE    = 16,
  parameter int X_BITS    = 4,
  parameter int Y_BITS    = 4,
  parameter int TICK_DIV  = 50_000_000,
  parameter int TIMER_MAX = 999
) (
  input  logic clk,
  input  logic reset_n,
  minesweeper_game_ctrl_if.slave bus
);
  localparam int CNT_W = X_BITS + Y_BITS + 1;
  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(X_SIZE - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(Y_SIZE - 1);

  typedef enum logic [3:0] {
    INIT = 4'b0001,
    PLAY = 4'b0010,
    WIN  = 4'b0100,
    LOSE = 4'b1000
  } state_t;

  state_t            st, st_n;
  logic [X_BITS-1:0] x, x_n;
  logic [Y_BITS-1:0] y, y_n;
  logic              oreq, oreq_n;
  logic              freq, freq_n;
  logic [CNT_W-1:0]  cells, cells_n;
  logic [CNT_W:0]    flags, flags_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st    <= INIT;
      x     <= '0;
      y     <= '0;
      oreq  <= 1'b0;
      freq  <= 1'b0;
      cells <= '0;
      flags <= '0;
    end else begin
      st    <= st_n;
      x     <= x_n;
      y     <= y_n;
      oreq  <= oreq_n;
      freq  <= freq_n;
      cells <= cells_n;
      flags <= flags_n;
    end
  end

  always_comb begin
    st_n    = st;
    x_n     = x;
    y_n     = y;
    oreq_n  = 1'b0;
    freq_n  = 1'b0;
    cells_n = cells;
    flags_n = flags;
    if (bus.new_game) begin
      st_n = INIT;
      x_n  = '0;
      y_n  = '0;
    end else begin
      case (st)
        INIT: begin
          if (bus.init_done) begin
            cells_n = bus.num_non_mines;
            flags_n = {1'b0, bus.num_mines};
            st_n    = PLAY;
          end
        end
        PLAY: begin
          // Cover-array events outrank user actions; requests and cursor
          // moves only apply on cycles with no cover-array event.
          if (bus.cell_opened && bus.cell_is_mine) begin
            st_n = LOSE;
          end else if (bus.cell_opened) begin
            cells_n = (cells == '0) ? '0 : cells - CNT_W'(1);
            if (cells <= CNT_W'(1)) st_n = WIN;
          end else if (bus.flag_changed) begin
            flags_n = bus.flag_set ? flags - (CNT_W+1)'(1) : flags + (CNT_W+1)'(1);
          end else begin
            oreq_n = bus.act_open;
            freq_n = bus.act_flag & ~bus.act_open;
            // Opposing moves in the same cycle cancel.
            if (bus.mv_l && !bus.mv_r)
              x_n = (x == '0) ? (bus.wrap_en ? X_MAX : '0) : x - X_BITS'(1);
            else if (bus.mv_r && !bus.mv_l)
              x_n = (x == X_MAX) ? (bus.wrap_en ? '0 : x) : x + X_BITS'(1);
            if (bus.mv_u && !bus.mv_d)
              y_n = (y == '0) ? (bus.wrap_en ? Y_MAX : '0) : y - Y_BITS'(1);
            else if (bus.mv_d && !bus.mv_u)
              y_n = (y == Y_MAX) ? (bus.wrap_en ? '0 : y) : y + Y_BITS'(1);
          end
        end
        WIN, LOSE: begin
          // Game over: open button doubles as restart.
          if (bus.act_open) begin
            st_n = INIT;
            x_n  = '0;
            y_n  = '0;
          end
        end
        default: st_n = INIT;
      endcase
    end
  end

`ifdef MINESWEEPER_TIMER_EN
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [9:0]        SEC_MAX   = 10'(TIMER_MAX);

  logic [TICK_W-1:0] tick, tick_n;
  logic [9:0]        sec, sec_n;

  // Cleared whenever heading into or sitting in INIT, so PLAY always starts
  // from a fresh second; counts only while in PLAY, holds in WIN/LOSE.
  always_comb begin
    tick_n = tick;
    sec_n  = sec;
    if (st_n == INIT || st == INIT) begin
      tick_n = '0;
      sec_n  = '0;
    end else if (st == PLAY) begin
      if (tick == TICK_LAST) begin
        tick_n = '0;
        if (sec < SEC_MAX) sec_n = sec + 10'd1;
      end else begin
        tick_n = tick + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick <= '0;
      sec  <= '0;
    end else begin
      tick <= tick_n;
      sec  <= sec_n;
    end
  end

  assign bus.elapsed_sec = sec;
`else
  assign bus.elapsed_sec = '0;
`endif

  assign bus.state         = st;
  assign bus.x_pos         = x;
  assign bus.y_pos         = y;
  assign bus.open_req      = oreq;
  assign bus.flag_req      = freq;
  assign bus.cells_to_open = cells;
  assign bus.flags_left    = flags;
endmodule

// File: tb/tb_minesweeper_game_ctrl.sv
// Testbench for minesweeper_game_ctrl: table of {inputs, expected outputs}
// records driven through a scoreboard queue, plus hand-written sequences for
// the flag underflow, timer saturation and asynchronous reset cases.
module tb_minesweeper_game_ctrl;
  localparam int CNT_W = 9;
  localparam logic [3:0] S_INIT = 4'b0001, S_PLAY = 4'b0010,
                         S_WIN  = 4'b0100, S_LOSE = 4'b1000;

  typedef logic [12:0] in_t;
  localparam in_t P_NG = 13'h0001, P_IN = 13'h0002, P_L  = 13'h0004,
                  P_R  = 13'h0008, P_U  = 13'h0010, P_D  = 13'h0020,
                  P_WR = 13'h0040, P_AO = 13'h0080, P_AF = 13'h0100,
                  P_CO = 13'h0200, P_CM = 13'h0400, P_FC = 13'h0800,
                  P_FS = 13'h1000;

  typedef struct {
    in_t              in;
    logic [CNT_W-1:0] nm;
    logic [CNT_W-1:0] nnm;
    logic [3:0]       st;
    logic [3:0]       x;
    logic [3:0]       y;
    logic [CNT_W-1:0] cells;
    logic [CNT_W:0]   flags;
    logic             oreq;
    logic             freq;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  minesweeper_game_ctrl_if #(.X_BITS(4), .Y_BITS(4)) bus();

  minesweeper_game_ctrl #(
    .X_SIZE(16), .Y_SIZE(16), .X_BITS(4), .Y_BITS(4),
    .TICK_DIV(4), .TIMER_MAX(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  function automatic vec_t mk(input in_t i, input int nm, input int nnm,
                              input logic [3:0] st, input int x, input int y,
                              input int cells, input int flags,
                              input bit o, input bit f);
    vec_t v;
    v.in = i; v.nm = 9'(nm); v.nnm = 9'(nnm); v.st = st;
    v.x = 4'(x); v.y = 4'(y); v.cells = 9'(cells); v.flags = 10'(flags);
    v.oreq = o; v.freq = f;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.new_game      = t.in[0];
    bus.init_done     = t.in[1];
    bus.mv_l          = t.in[2];
    bus.mv_r          = t.in[3];
    bus.mv_u          = t.in[4];
    bus.mv_d          = t.in[5];
    bus.wrap_en       = t.in[6];
    bus.act_open      = t.in[7];
    bus.act_flag      = t.in[8];
    bus.cell_opened   = t.in[9];
    bus.cell_is_mine  = t.in[10];
    bus.flag_changed  = t.in[11];
    bus.flag_set      = t.in[12];
    bus.num_mines     = t.nm;
    bus.num_non_mines = t.nnm;
  endtask

  task automatic idle();
    drive(mk('0, 0, 0, S_INIT, 0, 0, 0, 0, 0, 0));
  endtask

  // Drive one record, let one rising edge pass, compare one cycle later's view.
  task automatic apply(input vec_t t, input string tag);
    vec_t e;
    drive(t);
    sb.push_back(t);
    @(posedge clk);
    #1;
    idle();
    e = sb.pop_front();
    chk({tag, ".state"}, 32'(bus.state), 32'(e.st));
    chk({tag, ".x"}, 32'(bus.x_pos), 32'(e.x));
    chk({tag, ".y"}, 32'(bus.y_pos), 32'(e.y));
    chk({tag, ".cells"}, 32'(bus.cells_to_open), 32'(e.cells));
    chk({tag, ".flags"}, 32'(bus.flags_left), 32'(e.flags));
    chk({tag, ".open_req"}, 32'(bus.open_req), 32'(e.oreq));
    chk({tag, ".flag_req"}, 32'(bus.flag_req), 32'(e.freq));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sec;
    idle();
    //              inputs              nm  nnm  state   x   y  cells flags o f
    tbl.push_back(mk(P_IN,              40, 216, S_PLAY, 0,  0, 216, 40,   0,0)); // 0
    tbl.push_back(mk(P_L,               0,  0,   S_PLAY, 0,  0, 216, 40,   0,0)); // clamp left
    tbl.push_back(mk(P_L|P_WR,          0,  0,   S_PLAY, 15, 0, 216, 40,   0,0)); // wrap left
    tbl.push_back(mk(P_R|P_WR,          0,  0,   S_PLAY, 0,  0, 216, 40,   0,0)); // wrap right
    tbl.push_back(mk(P_U|P_D|P_WR,      0,  0,   S_PLAY, 0,  0, 216, 40,   0,0)); // cancel
    tbl.push_back(mk(P_D,               0,  0,   S_PLAY, 0,  1, 216, 40,   0,0));
    tbl.push_back(mk(P_U,               0,  0,   S_PLAY, 0,  0, 216, 40,   0,0));
    tbl.push_back(mk(P_U,               0,  0,   S_PLAY, 0,  0, 216, 40,   0,0)); // clamp up
    tbl.push_back(mk(P_R,               0,  0,   S_PLAY, 1,  0, 216, 40,   0,0));
    tbl.push_back(mk(P_R|P_L,           0,  0,   S_PLAY, 1,  0, 216, 40,   0,0)); // cancel
    tbl.push_back(mk(P_AO|P_AF,         0,  0,   S_PLAY, 1,  0, 216, 40,   1,0)); // open wins
    tbl.push_back(mk('0,                0,  0,   S_PLAY, 1,  0, 216, 40,   0,0)); // width 1
    tbl.push_back(mk(P_AF,              0,  0,   S_PLAY, 1,  0, 216, 40,   0,1));
    tbl.push_back(mk('0,                0,  0,   S_PLAY, 1,  0, 216, 40,   0,0));
    tbl.push_back(mk(P_CO,              0,  0,   S_PLAY, 1,  0, 215, 40,   0,0));
    tbl.push_back(mk(P_FC|P_FS,         0,  0,   S_PLAY, 1,  0, 215, 39,   0,0));
    tbl.push_back(mk(P_FC,              0,  0,   S_PLAY, 1,  0, 215, 40,   0,0));
    tbl.push_back(mk(P_CO|P_CM,         0,  0,   S_LOSE, 1,  0, 215, 40,   0,0)); // 17
    tbl.push_back(mk(P_R,               0,  0,   S_LOSE, 1,  0, 215, 40,   0,0)); // frozen
    tbl.push_back(mk(P_AF|P_CO|P_FC|P_FS,0, 0,   S_LOSE, 1,  0, 215, 40,   0,0));
    tbl.push_back(mk(P_AO,              0,  0,   S_INIT, 0,  0, 215, 40,   0,0)); // restart
    tbl.push_back(mk(P_IN,              2,  1,   S_PLAY, 0,  0, 1,   2,    0,0));
    tbl.push_back(mk(P_CO,              0,  0,   S_WIN,  0,  0, 0,   2,    0,0)); // last cell
    tbl.push_back(mk(P_R,               0,  0,   S_WIN,  0,  0, 0,   2,    0,0));
    tbl.push_back(mk(P_AO,              0,  0,   S_INIT, 0,  0, 0,   2,    0,0));
    tbl.push_back(mk(P_IN,              40, 216, S_PLAY, 0,  0, 216, 40,   0,0)); // 25
    tbl.push_back(mk(P_R,               0,  0,   S_PLAY, 1,  0, 216, 40,   0,0));
    tbl.push_back(mk(P_U|P_WR,          0,  0,   S_PLAY, 1,  15,216, 40,   0,0));
    tbl.push_back(mk(P_D|P_WR,          0,  0,   S_PLAY, 1,  0, 216, 40,   0,0));
    tbl.push_back(mk(P_NG,              0,  0,   S_INIT, 0,  0, 216, 40,   0,0));
    tbl.push_back(mk(P_IN,              40, 216, S_PLAY, 0,  0, 216, 40,   0,0)); // 30

    // Reset state, sampled while reset_n is held low.
    #12;
    chk("rst.state", 32'(bus.state), 32'(S_INIT));
    chk("rst.x", 32'(bus.x_pos), 32'd0);
    chk("rst.y", 32'(bus.y_pos), 32'd0);
    chk("rst.open_req", 32'(bus.open_req), 32'd0);
    chk("rst.flag_req", 32'(bus.flag_req), 32'd0);
    chk("rst.cells", 32'(bus.cells_to_open), 32'd0);
    chk("rst.flags", 32'(bus.flags_left), 32'd0);
    chk("rst.elapsed", 32'(bus.elapsed_sec), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // 41 flags placed from 40 mines: count goes negative without saturating.
    for (int k = 1; k <= 41; k++)
      apply(mk(P_FC|P_FS, 0, 0, S_PLAY, 0, 0, 216, 40 - k, 0, 0), $sformatf("flag%0d", k));
    apply(mk(P_CO|P_CM, 0, 0, S_LOSE, 0, 0, 216, -1, 0, 0), "mine");
    apply(mk(P_CO|P_FC|P_FS, 0, 0, S_LOSE, 0, 0, 216, -1, 0, 0), "lose_frozen");

    // Timer: TICK_DIV=4 cycles per second, saturating at 3.
    apply(mk(P_NG, 0, 0, S_INIT, 0, 0, 216, -1, 0, 0), "ng");
    chk("ng.elapsed", 32'(bus.elapsed_sec), 32'd0);
    apply(mk(P_IN, 40, 216, S_PLAY, 0, 0, 216, 40, 0, 0), "tinit");
    for (int k = 1; k <= 20; k++) begin
      apply(mk('0, 0, 0, S_PLAY, 0, 0, 216, 40, 0, 0), $sformatf("t%0d", k));
`ifdef MINESWEEPER_TIMER_EN
      exp_sec = (k / 4 > 3) ? 3 : k / 4;
`else
      exp_sec = 0;
`endif
      chk($sformatf("t%0d.elapsed", k), 32'(bus.elapsed_sec), 32'(exp_sec));
    end

    // Asynchronous reset while open_req is high.
    bus.act_open = 1'b1;
    @(posedge clk);
    #1;
    idle();
    chk("ar.open_req_hi", 32'(bus.open_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar.open_req", 32'(bus.open_req), 32'd0);
    chk("ar.state", 32'(bus.state), 32'(S_INIT));
    chk("ar.cells", 32'(bus.cells_to_open), 32'd0);
    chk("ar.flags", 32'(bus.flags_left), 32'd0);
    chk("ar.elapsed", 32'(bus.elapsed_sec), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
